dcm_spi_master: RTL

DCM_SPI_MASTER -- requirements
Module: dcm_spi_master

---
 rtl/dcm_spi_master_pkg.sv | 26 ++
 rtl/dcm_spi_master_if.sv | 10 +
 rtl/dcm_spi_clkgen.sv | 33 +++
 rtl/dcm_spi_master.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/dcm_spi_master_pkg.sv
// Shared types and constants for the DCM SPI master and its users.
package dcm_pkg;

  // Master sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOW   = 3'd2,
    ST_HIGH  = 3'd3,
    ST_FETCH = 3'd4,
    ST_HOLD  = 3'd5
  } state_t;

  // Command byte fields: bit7 selects write, bit6 selects the channel register.
  localparam logic [7:0] CMD_WRITE  = 8'h80;
  localparam logic [7:0] CMD_CH_SEL = 8'h40;

  // Data bytes in one per-channel frame.
  localparam int FRAME_LEN = 4;

  // Timing defaults, all in clk cycles.
  localparam int CLKDIV_DEFAULT   = 5;
  localparam int SS_SETUP_DEFAULT = 5;
  localparam int SS_HOLD_DEFAULT  = 10;

endpackage

// File: rtl/dcm_spi_master_if.sv
// SPI pin bundle; the master drives select/clock/data, the slave drives miso.
interface dcm_spi_master_if;
  logic spi_ss;
  logic spi_clk;
  logic spi_mosi;
  logic spi_miso;

  modport master (output spi_ss, output spi_clk, output spi_mosi, input spi_miso);
  modport slave  (input spi_ss, input spi_clk, input spi_mosi, output spi_miso);
endinterface

// File: rtl/dcm_spi_clkgen.sv
// Half-period timer for spi_clk. While enabled it alternates a low half and a
// high half of CLKDIV cycles each; rise_tick marks the last cycle of a low half,
// fall_tick the last cycle of a high half. Disabling it rearms a low half.
module dcm_spi_clkgen #(
  parameter int CLKDIV = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic rise_tick,
  output logic fall_tick
);

  logic [7:0] cnt;
  logic       phase;

  // Down-count each half period, flip phase at terminal count.
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      cnt   <= 8'(CLKDIV - 1);
      phase <= 1'b0;
    end else if (cnt == 8'd0) begin
      cnt   <= 8'(CLKDIV - 1);
      phase <= ~phase;
    end else begin
      cnt <= cnt - 8'd1;
    end
  end

  assign rise_tick = en && (cnt == 8'd0) && !phase;
  assign fall_tick = en && (cnt == 8'd0) && phase;

endmodule

// File: rtl/dcm_spi_master.sv
// SPI master for the DCM: sends a command byte followed by len data bytes,
// MSB first, spi_clk idle high, returning the bytes read back on miso.
//
// state | meaning
// IDLE  | waiting for start, spi_ss high
// SETUP | spi_ss low, waiting SS_SETUP cycles before the first clock
// LOW   | spi_clk low half of a bit, mosi presents the bit
// HIGH  | spi_clk high half of a bit, miso sampled on its last cycle
// FETCH | between bytes, spi_clk held high until tx_valid
// HOLD  | spi_ss high for SS_HOLD cycles before busy drops
module dcm_spi_master
  import dcm_pkg::*;
#(
  parameter int CLKDIV   = CLKDIV_DEFAULT,
  parameter int SS_SETUP = SS_SETUP_DEFAULT,
  parameter int SS_HOLD  = SS_HOLD_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] cmd,
  input  logic [7:0] len,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       done,
  dcm_spi_master_if.master spi
);

  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic [7:0] sh;
  logic [7:0] remaining;
  logic [2:0] bit_cnt;
  logic       is_data;
  logic       mosi_q;
  logic       clk_en;
  logic       rise_tick, fall_tick;

  dcm_spi_clkgen #(.CLKDIV(CLKDIV)) u_clkgen (
    .clk      (clk),
    .reset    (reset),
    .en       (clk_en),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode and state-derived strobes.
  always_comb begin
    state_nxt = state;
    clk_en    = 1'b0;
    tx_ready  = 1'b0;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_SETUP;
      ST_SETUP: if (cnt == 8'd0) state_nxt = ST_LOW;
      ST_LOW: begin
        clk_en = 1'b1;
        if (rise_tick) state_nxt = ST_HIGH;
      end
      ST_HIGH: begin
        clk_en = 1'b1;
        if (fall_tick) begin
          if (bit_cnt != 3'd0)        state_nxt = ST_LOW;
          else if (remaining != 8'd0) state_nxt = ST_FETCH;
          else                        state_nxt = ST_HOLD;
        end
      end
      ST_FETCH: begin
        tx_ready = 1'b1;
        if (tx_valid) state_nxt = ST_LOW;
      end
      ST_HOLD:  if (cnt == 8'd0) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: capture, phase timer, shift register, byte countdown, strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= 8'd0;
      sh        <= 8'd0;
      remaining <= 8'd0;
      bit_cnt   <= 3'd0;
      is_data   <= 1'b0;
      mosi_q    <= 1'b0;
      rx_data   <= 8'd0;
      rx_valid  <= 1'b0;
      done      <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            sh        <= cmd;
            remaining <= len;
            is_data   <= 1'b0;
            bit_cnt   <= 3'd7;
            cnt       <= 8'(SS_SETUP - 1);
          end
        end
        ST_SETUP: begin
          if (cnt == 8'd0) mosi_q <= sh[7];
          else             cnt    <= cnt - 8'd1;
        end
        ST_HIGH: begin
          if (fall_tick) begin
            sh      <= {sh[6:0], spi.spi_miso};
            bit_cnt <= bit_cnt - 3'd1;
            if (bit_cnt != 3'd0) begin
              // sh[6] is the next bit once this shift lands.
              mosi_q <= sh[6];
            end else begin
              if (is_data) begin
                rx_data  <= {sh[6:0], spi.spi_miso};
                rx_valid <= 1'b1;
              end
              if (remaining == 8'd0) cnt <= 8'(SS_HOLD - 1);
            end
          end
        end
        ST_FETCH: begin
          if (tx_valid) begin
            sh        <= tx_data;
            mosi_q    <= tx_data[7];
            remaining <= remaining - 8'd1;
            is_data   <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (cnt == 8'd0) done <= 1'b1;
          else             cnt  <= cnt - 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy         = (state != ST_IDLE);
  assign spi.spi_ss   = (state == ST_IDLE) || (state == ST_HOLD);
  assign spi.spi_clk  = (state != ST_LOW);
  assign spi.spi_mosi = mosi_q;

endmodule
